// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), one iteration per clock.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   ALUShamt,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Zero,
    output logic             Overflow,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_ORI  = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_reg, state_next;
    logic [SHW-1:0]   count_reg;
    logic [WIDTH-1:0] work_hi_reg, work_lo_reg, operand_reg;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf, last_iter;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next, div_hi_next, div_lo_next;

    assign busy      = (state_reg != IDLE);
    assign last_iter = (count_reg == SHW'(WIDTH - 1));
    assign sum       = A + B;
    assign diff      = A - B;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUOperation)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOR:  alu_res = ~(A | B);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL:  alu_res = B << ALUShamt;
            OP_SRL:  alu_res = B >> ALUShamt;
            OP_SRA:  alu_res = $signed(B) >>> ALUShamt;
            OP_ORI:  alu_res = A | B;
            OP_LUI:  alu_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  alu_res = A ^ B;
            default: alu_res = '0;
        endcase
    end

    // Multiply: {work_hi, work_lo} is the product register; the multiplier
    // sits in work_lo and is consumed from the LSB as the product shifts in.
    always_comb begin
        mul_sum     = {1'b0, work_hi_reg} + {1'b0, (work_lo_reg[0] ? operand_reg : '0)};
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    end

    // Divide: work_hi is the partial remainder, work_lo shifts the dividend
    // out and the quotient in. A zero divisor yields all-ones / dividend.
    always_comb begin
        div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, operand_reg};
        if (!div_trial[WIDTH]) begin
            div_hi_next = div_trial[WIDTH-1:0];
            div_lo_next = {work_lo_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_next = div_shift[WIDTH-1:0];
            div_lo_next = {work_lo_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) begin
                if (ALUOperation == OP_MULU)      state_next = MUL;
                else if (ALUOperation == OP_DIVU) state_next = DIV;
            end
            MUL:     if (last_iter) state_next = IDLE;
            DIV:     if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            operand_reg <= '0;
            ALUResult   <= '0;
            HI          <= '0;
            LO          <= '0;
            Zero        <= 1'b1;
            Overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    count_reg <= '0;
                    if (ALUOperation == OP_MULU) begin
                        work_hi_reg <= '0;
                        work_lo_reg <= B;
                        operand_reg <= A;
                    end else if (ALUOperation == OP_DIVU) begin
                        work_hi_reg <= '0;
                        work_lo_reg <= A;
                        operand_reg <= B;
                    end else begin
                        ALUResult <= alu_res;
                        Zero      <= (alu_res == '0);
                        Overflow  <= alu_ovf;
                        done      <= 1'b1;
                    end
                end
                MUL: begin
                    count_reg   <= count_reg + 1'b1;
                    work_hi_reg <= mul_hi_next;
                    work_lo_reg <= mul_lo_next;
                    if (last_iter) begin
                        HI        <= mul_hi_next;
                        LO        <= mul_lo_next;
                        ALUResult <= mul_lo_next;
                        Zero      <= (mul_lo_next == '0);
                        Overflow  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DIV: begin
                    count_reg   <= count_reg + 1'b1;
                    work_hi_reg <= div_hi_next;
                    work_lo_reg <= div_lo_next;
                    if (last_iter) begin
                        HI        <= div_hi_next;
                        LO        <= div_lo_next;
                        ALUResult <= div_lo_next;
                        Zero      <= (div_lo_next == '0);
                        Overflow  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
